// File: rtl/if_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package if_pkg;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam int unsigned PC_INC            = 4;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures {pc, instruction, valid} for decode.
// Latency: 1 cycle from i_load to outputs.
// Backpressure: holds its contents when neither i_load nor i_bubble is set.
//
// Ports:
//   i_clk, i_rst          clock, async active-low reset
//   i_load                capture i_pc/i_instruction/i_valid
//   i_bubble              keep pc, replace entry with an invalid NOP
//   i_pc/i_instruction/i_valid  entry to capture
//   o_pc/o_instruction/o_valid  registered entry
module if_id_reg
  import if_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_bubble,
  input  logic [NBITS-1:0] i_pc,
  input  logic [NBITS-1:0] i_instruction,
  input  logic             i_valid,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_instruction,
  output logic             o_valid
);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_pc          <= '0;
      o_instruction <= NBITS'(NOP_WORD);
      o_valid       <= 1'b0;
    end else if (i_load) begin
      o_pc          <= i_pc;
      o_instruction <= i_instruction;
      o_valid       <= i_valid;
    end else if (i_bubble) begin
      // pc is left alone so the debug view still points at the halt
      o_instruction <= NBITS'(NOP_WORD);
      o_valid       <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle sync imem, feeds IF/ID.
// Latency: address issued at edge n reaches IF/ID after edge n+2.
// Backpressure: stall/disable freezes PC, in-flight fetch and IF/ID; imem_en
//   drops so the memory holds its word and nothing is lost or duplicated.
//
// Ports:
//   i_clk, i_rst                    clock, async active-low reset
//   i_enable, i_hazard_detected     debug run/step enable, load-use stall
//   i_pc_redirect, i_redirect_target  taken jump/branch from decode
//   o_imem_addr, o_imem_en, i_imem_data  instruction memory interface
//   o_pc, o_instruction, o_valid    IF/ID contents
//   o_fetch_pc, o_halted            debug view of PC and halt status
module instruction_fetch_stage
  import if_pkg::*;
#(
  parameter int               NBITS     = 32,
  parameter logic [NBITS-1:0] PC_RESET  = '0,
  parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_hazard_detected,
  input  logic             i_pc_redirect,
  input  logic [NBITS-1:0] i_redirect_target,
  output logic [NBITS-1:0] o_imem_addr,
  output logic             o_imem_en,
  input  logic [NBITS-1:0] i_imem_data,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_instruction,
  output logic             o_valid,
  output logic [NBITS-1:0] o_fetch_pc,
  output logic             o_halted
);

  logic [NBITS-1:0] r_pc;
  logic [NBITS-1:0] r_pc_f;
  logic             r_fv;
  fetch_state_e     r_state;
  fetch_state_e     state_nxt;

  logic             adv;
  logic             drain;
  logic             halt_cap;
  logic [NBITS-1:0] fetch_word;

  assign adv   = i_enable & ~i_hazard_detected & (r_state == ST_RUN);
  assign drain = i_enable & ~i_hazard_detected & (r_state == ST_HALT);

  // A squashed in-flight fetch enters IF/ID as a NOP regardless of memory data
  assign fetch_word = r_fv ? i_imem_data : NBITS'(NOP_WORD);

  // HALT is recognised as it is captured, so halt and IF/ID load share an edge
  assign halt_cap = adv & r_fv & (i_imem_data == HALT_WORD);

  assign o_imem_en   = adv & i_rst;
  assign o_imem_addr = r_pc;
  assign o_fetch_pc  = r_pc;
  assign o_halted    = (r_state == ST_HALT);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (halt_cap) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc   <= PC_RESET;
      r_pc_f <= '0;
      r_fv   <= 1'b0;
    end else if (adv) begin
      r_pc_f <= r_pc;
      // HALT beats a redirect on the same edge: PC keeps counting to halt+8
      if (i_pc_redirect && !halt_cap) begin
        r_pc <= {i_redirect_target[NBITS-1:2], 2'b00};
        r_fv <= 1'b0;  // kill the fetch behind the delay slot
      end else begin
        r_pc <= r_pc + NBITS'(PC_INC);
        r_fv <= 1'b1;
      end
    end
  end

  if_id_reg #(
    .NBITS (NBITS)
  ) u_if_id_reg (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_load        (adv),
    .i_bubble      (drain),
    .i_pc          (r_pc_f),
    .i_instruction (fetch_word),
    .i_valid       (r_fv),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .o_valid       (o_valid)
  );

endmodule
